// File: rtl/maxpool_engine.sv
// maxpool_engine: sequential 2x2 stride-2 max-pool over one feature map.
// Reads four elements per window from a synchronous-read buffer and writes
// one pooled element per window in raster order.
// Optional build macro: MAXPOOL_RELU_EN (fused ReLU on the written value).
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | waiting for maxp_run
// S_RD0   | read window element (dy,dx)=(0,0)
// S_RD1   | read (0,1); load acc with the (0,0) data
// S_RD2   | read (1,0); acc = max(acc, (0,1) data)
// S_RD3   | read (1,1); acc = max(acc, (1,0) data)
// S_WR    | write max(acc, (1,1) data); advance ox/oy
// S_DONE  | one-cycle maxp_done pulse
module maxpool_engine #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              maxp_run,
  output logic              maxp_done,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  localparam logic [ADDR_W-1:0] OW_A  = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] OW_M1 = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OH_M1 = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] IW_A  = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WR, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        ox_q, ox_d, oy_q, oy_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;

  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              done_q, done_d;

  logic signed [DATA_W-1:0] rd_s, max_s;
  logic                     last_win;
  logic [ADDR_W-1:0]        dy, dx;

  assign rd_s     = $signed(rd_data);
  assign max_s    = (rd_s > acc_q) ? rd_s : acc_q;
  assign last_win = (ox_q == OW_M1) && (oy_q == OH_M1);

  // Next state, window counters and running maximum.
  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (maxp_run) begin
          state_d = S_RD0;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        state_d = S_RD2;
        acc_d   = rd_s;
      end
      S_RD2: begin
        state_d = S_RD3;
        acc_d   = max_s;
      end
      S_RD3: begin
        state_d = S_WR;
        acc_d   = max_s;
      end
      S_WR: begin
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD0;
          if (ox_q == OW_M1) begin
            ox_d = '0;
            oy_d = oy_q + 1'b1;
          end else begin
            ox_d = ox_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, so every strobe/address is a flop.
  always_comb begin
    dy = '0;
    dx = '0;
    case (state_d)
      S_RD1:   dx = 1'b1;
      S_RD2:   dy = 1'b1;
      S_RD3: begin
        dy = 1'b1;
        dx = 1'b1;
      end
      default: ;
    endcase
    busy_d    = (state_d != S_IDLE);
    rd_en_d   = state_d inside {S_RD0, S_RD1, S_RD2, S_RD3};
    rd_addr_d = rd_en_d ? ((oy_d + oy_d + dy) * IW_A + ox_d + ox_d + dx) : '0;
    wr_en_d   = (state_d == S_WR);
    wr_addr_d = wr_en_d ? (oy_d * OW_A + ox_d) : '0;
    done_d    = (state_d == S_DONE);
  end

  // Pooled value uses the fourth read directly; zero outside WR.
  always_comb begin
    wr_data = '0;
    if (state_q == S_WR) begin
`ifdef MAXPOOL_RELU_EN
      wr_data = max_s[DATA_W-1] ? '0 : max_s;
`else
      wr_data = max_s;
`endif
    end
  end

  // State, counters, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign maxp_done = done_q;

endmodule

// File: tb/tb_maxpool_engine.sv
// Bench for maxpool_engine: three instances (4x4, 5x5, 2x2 maps), each with
// its own synchronous-read input buffer and write monitor.
module tb_maxpool_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        run     [3];
  logic        done    [3];
  logic        busy    [3];
  logic        rd_en   [3];
  logic        wr_en   [3];
  logic [9:0]  rd_addr [3];
  logic [9:0]  wr_addr [3];
  logic [31:0] rd_data [3];
  logic [31:0] wr_data [3];
  logic [31:0] mem     [3][1024];

  int iw [3] = '{4, 5, 2};
  int ih [3] = '{4, 5, 2};

  int          wr_cnt   [3];
  int          done_cnt [3];
  int          done_cyc [3];
  int          log_addr [3][64];
  logic [31:0] log_data [3][64];
  int          bad_rd;

  int n_assert = 0;
  int n_fail   = 0;
  int c0;

  maxpool_engine #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .ADDR_W(10)) u_a (
    .clk(clk), .rst_n(rst_n), .maxp_run(run[0]), .maxp_done(done[0]), .busy(busy[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]));

  maxpool_engine #(.DATA_W(32), .IMG_W(5), .IMG_H(5), .ADDR_W(10)) u_b (
    .clk(clk), .rst_n(rst_n), .maxp_run(run[1]), .maxp_done(done[1]), .busy(busy[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]));

  maxpool_engine #(.DATA_W(32), .IMG_W(2), .IMG_H(2), .ADDR_W(10)) u_c (
    .clk(clk), .rst_n(rst_n), .maxp_run(run[2]), .maxp_done(done[2]), .busy(busy[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]));

  // Input buffers: one-cycle synchronous read.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rd_en[i]) rd_data[i] <= mem[i][rd_addr[i]];
  end

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr_en[i]) begin
        if (wr_cnt[i] < 64) begin
          log_addr[i][wr_cnt[i]] = int'(wr_addr[i]);
          log_data[i][wr_cnt[i]] = wr_data[i];
        end
        wr_cnt[i]++;
      end
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
    end
    if (rd_en[1] && (rd_addr[1] >= 10'd20 || (rd_addr[1] % 10'd5) == 10'd4)) bad_rd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_zero(input int i, input string tag);
    chk({tag, "_busy"},    32'(busy[i]),    0);
    chk({tag, "_done"},    32'(done[i]),    0);
    chk({tag, "_rd_en"},   32'(rd_en[i]),   0);
    chk({tag, "_wr_en"},   32'(wr_en[i]),   0);
    chk({tag, "_rd_addr"}, 32'(rd_addr[i]), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr[i]), 0);
    chk({tag, "_wr_data"}, wr_data[i],      0);
  endtask

  // Reference: signed max over each 2x2 window, optional ReLU.
  function automatic logic [31:0] ref_pool(input int i, input int ox, input int oy);
    int w = iw[i];
    int m;
    int v;
    m = int'(mem[i][(2*oy)*w + 2*ox]);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'(mem[i][(2*oy+dy)*w + 2*ox + dx]);
        if (v > m) m = v;
      end
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return 32'(m);
  endfunction

  task automatic fill(input int i, input int mode);
    for (int k = 0; k < iw[i]*ih[i]; k++) begin
      case (mode)
        0:       mem[i][k] = 32'(k);
        1:       mem[i][k] = $urandom;
        default: mem[i][k] = 32'(int'($urandom_range(0, 15)) - 8);
      endcase
    end
  endtask

  task automatic check_map(input int i, input int base, input string tag);
    int ow = iw[i] / 2;
    int oh = ih[i] / 2;
    for (int k = 0; k < ow*oh; k++) begin
      chk({tag, "_addr"}, 32'(log_addr[i][base+k]), 32'(k));
      chk({tag, "_data"}, log_data[i][base+k], ref_pool(i, k % ow, k / ow));
    end
  endtask

  task automatic start(input int i);
    @(negedge clk);
    run[i] = 1'b1;
    c0 = cyc;
    @(negedge clk);
    run[i] = 1'b0;
  endtask

  task automatic run_map(input int i, input string tag);
    int n = (iw[i]/2) * (ih[i]/2);
    wr_cnt[i]   = 0;
    done_cnt[i] = 0;
    start(i);
    repeat (5*n + 6) @(negedge clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt[i]), 1);
    chk({tag, "_done_cyc"}, 32'(done_cyc[i] - c0), 32'(5*n + 1));
    chk({tag, "_wr_cnt"},   32'(wr_cnt[i]), 32'(n));
    check_map(i, 0, tag);
  endtask

  initial begin
    int c1;
    int t;
    logic [31:0] exp4 [4];
    logic [31:0] exp5 [4];
    exp4 = '{32'd5, 32'd7, 32'd13, 32'd15};
    exp5 = '{32'd6, 32'd8, 32'd16, 32'd18};
    bad_rd = 0;
    for (int i = 0; i < 3; i++) begin
      run[i] = 1'b0; wr_cnt[i] = 0; done_cnt[i] = 0; done_cyc[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_outs_zero(i, "reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4x4 ramp
    fill(0, 0);
    run_map(0, "ramp4");
    for (int k = 0; k < 4; k++) chk("ramp4_const", log_data[0][k], exp4[k]);

    // 5x5 ramp: last row/column never read
    fill(1, 0);
    run_map(1, "ramp5");
    for (int k = 0; k < 4; k++) chk("ramp5_const", log_data[1][k], exp5[k]);
    chk("ramp5_no_edge_reads", 32'(bad_rd), 0);

    // 2x2 all negative
    mem[2][0] = -32'sd7; mem[2][1] = -32'sd3; mem[2][2] = -32'sd9; mem[2][3] = -32'sd5;
    run_map(2, "neg2");
`ifdef MAXPOOL_RELU_EN
    chk("neg2_const", log_data[2][0], 32'h0000_0000);
`else
    chk("neg2_const", log_data[2][0], 32'hFFFF_FFFD);
`endif

    // 2x2 extreme signed values
    mem[2][0] = 32'h8000_0000; mem[2][1] = 32'h7FFF_FFFF;
    mem[2][2] = 32'h8000_0000; mem[2][3] = 32'h8000_0000;
    run_map(2, "ext2");
    chk("ext2_const", log_data[2][0], 32'h7FFF_FFFF);

    // randomized maps on all three geometries
    for (int r = 0; r < 9; r++) begin
      fill(r % 3, 1 + (r / 3) % 2);
      run_map(r % 3, "rand");
    end
    chk("rand5_no_edge_reads", 32'(bad_rd), 0);

    // re-pulsed run while busy is ignored
    fill(0, 1);
    wr_cnt[0] = 0; done_cnt[0] = 0;
    start(0);
    repeat (26) begin
      run[0] = (cyc == c0 + 3) || (cyc == c0 + 12);
      @(negedge clk);
    end
    run[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("repulse_wr_cnt",   32'(wr_cnt[0]), 4);
    chk("repulse_done_cnt", 32'(done_cnt[0]), 1);
    chk("repulse_done_cyc", 32'(done_cyc[0] - c0), 21);
    check_map(0, 0, "repulse");

    // reset mid-map at cycle 8, held two cycles
    fill(0, 1);
    wr_cnt[0] = 0; done_cnt[0] = 0;
    start(0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs_zero(0, "midrst_a");
    @(negedge clk);
    chk_outs_zero(0, "midrst_b");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_done_cnt", 32'(done_cnt[0]), 0);
    chk("midrst_wr_cnt",   32'(wr_cnt[0]), 1);
    chk("midrst_busy",     32'(busy[0]), 0);
    fill(0, 1);
    run_map(0, "after_rst");

    // back-to-back maps
    fill(0, 2);
    wr_cnt[0] = 0; done_cnt[0] = 0;
    start(0);
    t = 0;
    while (!done[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_done_seen", 32'(done[0]), 1);
    chk("b2b_done1_cyc", 32'(cyc - c0), 21);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy[0]), 0);
    run[0] = 1'b1;
    c1 = cyc;
    @(negedge clk);
    run[0] = 1'b0;
    chk("b2b_start_busy",  32'(busy[0]), 1);
    chk("b2b_start_rd_en", 32'(rd_en[0]), 1);
    chk("b2b_start_addr",  32'(rd_addr[0]), 0);
    repeat (26) @(negedge clk);
    chk("b2b_done_cnt",  32'(done_cnt[0]), 2);
    chk("b2b_done2_cyc", 32'(done_cyc[0] - c1), 21);
    chk("b2b_wr_cnt",    32'(wr_cnt[0]), 8);
    check_map(0, 0, "b2b_first");
    check_map(0, 4, "b2b_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_engine.md
# maxpool_engine

Sequential 2x2, stride-2 max-pool engine for the CNN datapath. It sits directly downstream of the convolution/ReLU stage and is started by the layer controller's `maxp_run` pulse. It reads one output feature map from a single-port buffer with synchronous read and writes the pooled map to a second buffer. It returns `maxp_done` to the controller when the last result is written.

## Interface
- `DATA_W`, 32: feature-map element width; signed two's complement.
- `IMG_W`, 32: input map width in elements; must be ≥ 2.
- `IMG_H`, 32: input map height in elements; must be ≥ 2.
- `ADDR_W`, 10: read and write address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

Ports:
- `clk` input 1: the single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `maxp_run` input 1: start pulse from the controller; sampled only in IDLE.
- `maxp_done` output 1: one-cycle pulse when the pooled map is complete.
- `busy` output 1: high in every state except IDLE.
- `rd_en` output 1: input-buffer read strobe.
- `rd_addr` output ADDR_W: input-buffer read address.
- `rd_data` input DATA_W: input-buffer data, valid the cycle after `rd_en`.
- `wr_en` output 1: output-buffer write strobe.
- `wr_addr` output ADDR_W: output-buffer write address.
- `wr_data` output DATA_W: pooled value.

## Operation
- Output map size: OW = floor(IMG_W/2), OH = floor(IMG_H/2). With odd dimensions, the last input column and/or row is ignored.
- FSM states: IDLE, RD0, RD1, RD2, RD3, WR, DONE.
  - IDLE → RD0 on `maxp_run`=1. Output counters ox and oy clear to 0.
  - RD0 → RD1 → RD2 → RD3 → WR, unconditionally.
  - WR → RD0 if the current window is not the last one; otherwise WR → DONE.
  - DONE → IDLE, unconditionally.
- In RDk, `rd_en`=1. `rd_addr` = (2*oy+dy)*IMG_W + (2*ox+dx), with (dy,dx) = (0,0), (0,1), (1,0), (1,1) for k = 0..3.
- Accumulator `acc`:
  - Loaded with `rd_data` in RD1.
  - Updated to signed max(acc, `rd_data`) in RD2 and RD3.
  - In WR, `wr_data` = signed max(acc, `rd_data`), computed combinationally from the fourth read.
- In WR, `wr_en`=1 and `wr_addr` = oy*OW + ox. Results are written in raster order.
- After each WR, ox increments. When ox wraps from OW-1 to 0, oy increments.
- The last window is ox=OW-1, oy=OH-1.
- Comparison is signed over the full DATA_W. No arithmetic is performed, so no width growth occurs.
- `maxp_run` is ignored while `busy`=1. A repeated run request is not queued.
- Asserting `rst_n`=0 at any time, including mid-map, forces the following immediately:
  - State returns to IDLE.
  - Counters and `acc` clear.
  - Every output drops to 0.
  - No `maxp_done` is produced for the aborted map.
  - Partial writes already performed remain in the output buffer.

## Timing
- Reset values: `maxp_done`, `busy`, `rd_en`, `wr_en` = 0; `rd_addr`, `wr_addr`, `wr_data` = 0.
- All outputs are registered or decoded from registered state. No combinational path exists from `maxp_run` to any output.
- `wr_data` depends combinationally on `rd_data` in WR only.
- Sequence when `maxp_run` is sampled high at edge E0:
  - RD0 is active in the cycle after E0.
  - Each window takes 5 cycles.
  - The final WR cycle is cycle 5*OW*OH after E0.
  - `maxp_done` is high for exactly one cycle, in the next cycle (5*OW*OH + 1).
  - `busy` falls in the cycle after `maxp_done`.
- Back-to-back operation: a `maxp_run` sampled in the first IDLE cycle after DONE starts a new map. The minimum gap is one IDLE cycle.
- Read protocol: one read outstanding at a time, with a fixed latency of 1 cycle. The buffer must present `rd_data` the cycle after `rd_en`.

## Configuration
- `MAXPOOL_RELU_EN`:
  - Defined: fused ReLU. In WR, `wr_data` = 0 if the pooled max is negative; otherwise the max. This allows the controller to skip the standalone ReLU pass.
  - Undefined: `wr_data` is the raw signed max. Negative values pass through unchanged.
  - Timing, FSM and cycle counts are identical in both builds.

## Test plan
- 4x4 map, values 0..15 in raster order, run pulse → writes 5, 7, 13, 15 to addresses 0..3; `maxp_done` exactly 21 cycles after the run edge.
- 5x5 map, values 0..24 → writes 6, 8, 16, 18; row 4 and column 4 are never read (check `rd_addr` never ≥ 20 and never ≡ 4 mod 5).
- 2x2 map {-7, -3, -9, -5}:
  - Without `MAXPOOL_RELU_EN` → writes -3.
  - With `MAXPOOL_RELU_EN` → writes 0.
  - Also check 32'h80000000 vs 32'h7FFFFFFF → writes 7FFFFFFF.
- 4x4 map, `maxp_run` re-pulsed at cycles 3 and 12 → ignored. Exactly 4 writes occur and exactly one `maxp_done`, at cycle 21.
- 4x4 map, `rst_n` low for 2 cycles at cycle 8:
  - All outputs are 0 during reset.
  - No `maxp_done` is produced.
  - A fresh run afterwards completes normally with correct data.
- Back-to-back: second `maxp_run` in the first IDLE cycle after `maxp_done` → second map starts one cycle later and produces correct results.
